// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one SDRAM port between a ROM-download (boot) port, a CPU port and an
// aux (DMA/snapshot) port, one access per 16-clock slot framed by ce_ref.
//
// Ports
//   clk_sys, reset            : system clock, synchronous active-high reset
//   ce_ref                    : slot strobe, one clock wide, every 16 clocks
//   boot_mode                 : while high only the boot port is served
//   boot_req/addr/bank/din    : boot write request (level) and operands
//   boot_ack                  : one-clock pulse when the boot write completes
//   cpu_rd/wr/addr/bank/din   : CPU access strobes (levels) and operands
//   cpu_dout                  : CPU read data (8'hFF while boot_mode is high)
//   aux_req/we/addr/din       : aux request (level), direction and operands
//   aux_ack, aux_dout         : aux completion pulse, aux read data
//   sd_oe/we/addr/bank/din    : command towards the SDRAM controller
//   sd_dout                   : SDRAM read data
//   sd_clkref                 : ce_ref delayed one clock, aligned with command
//
// Slot timing: the counter reads 0 in the clock after ce_ref, which is also
// the first clock the command is visible. sd_dout is captured on the edge
// that ends counter==DOUT_LAT, and the acks are high during that same clock.
module ram_arbiter #(
  parameter int unsigned DOUT_LAT   = 8,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ce_ref,
  input  logic        boot_mode,
  input  logic        boot_req,
  input  logic [22:0] boot_addr,
  input  logic [1:0]  boot_bank,
  input  logic [7:0]  boot_din,
  output logic        boot_ack,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [22:0] cpu_addr,
  input  logic [1:0]  cpu_bank,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [22:0] aux_addr,
  input  logic [7:0]  aux_din,
  output logic        aux_ack,
  output logic [7:0]  aux_dout,
  output logic        sd_oe,
  output logic        sd_we,
  output logic [22:0] sd_addr,
  output logic [1:0]  sd_bank,
  output logic [7:0]  sd_din,
  input  logic [7:0]  sd_dout,
  output logic        sd_clkref
);

  localparam logic [3:0] LAT    = 4'(DOUT_LAT);
  localparam logic [3:0] LAT_M1 = 4'(DOUT_LAT - 1);
  localparam logic [3:0] STARVE = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BOOT, CPU, AUX} state_t;

  state_t      state_q, state_d;
  logic [3:0]  slotCnt_q, slotCnt_d;
  logic [3:0]  starve_q, starve_d;
  logic        sdOe_q, sdOe_d;
  logic        sdWe_q, sdWe_d;
  logic [22:0] sdAddr_q, sdAddr_d;
  logic [1:0]  sdBank_q, sdBank_d;
  logic [7:0]  sdDin_q, sdDin_d;
  logic        clkRef_q;
  logic        bootAck_q, bootAck_d;
  logic        auxAck_q, auxAck_d;
  logic [7:0]  cpuDout_q, cpuDout_d;
  logic [7:0]  auxDout_q, auxDout_d;

  // Grant decision: only evaluated on ce_ref, otherwise the winner holds.
  // An aux request that has lost STARVE_MAX slots in a row beats the CPU.
  always_comb begin
    state_d = state_q;
    if (ce_ref) begin
      if (boot_mode)
        state_d = boot_req ? BOOT : IDLE;
      else if (aux_req && (starve_q >= STARVE))
        state_d = AUX;
      else if (cpu_rd || cpu_wr)
        state_d = CPU;
      else if (aux_req)
        state_d = AUX;
      else
        state_d = IDLE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Datapath next-state: command latch, slot counter, starvation counter,
  // ack generation and read-data capture.
  always_comb begin
    sdOe_d    = sdOe_q;
    sdWe_d    = sdWe_q;
    sdAddr_d  = sdAddr_q;
    sdBank_d  = sdBank_q;
    sdDin_d   = sdDin_q;
    starve_d  = starve_q;
    cpuDout_d = cpuDout_q;
    auxDout_d = auxDout_q;
    slotCnt_d = (slotCnt_q == 4'd15) ? 4'd15 : slotCnt_q + 4'd1;

    if (ce_ref) begin
      slotCnt_d = 4'd0;
      case (state_d)
        BOOT: begin
          sdOe_d   = 1'b0;
          sdWe_d   = 1'b1;
          sdAddr_d = boot_addr;
          sdBank_d = boot_bank;
          sdDin_d  = boot_din;
        end
        CPU: begin
          // rd and wr together count as a write
          sdOe_d   = ~cpu_wr;
          sdWe_d   = cpu_wr;
          sdAddr_d = cpu_addr;
          sdBank_d = cpu_bank;
          sdDin_d  = cpu_din;
        end
        AUX: begin
          // the aux port has no bank select; it always lives in bank 0
          sdOe_d   = ~aux_we;
          sdWe_d   = aux_we;
          sdAddr_d = aux_addr;
          sdBank_d = 2'd0;
          sdDin_d  = aux_din;
        end
        default: begin
          sdOe_d = 1'b0;
          sdWe_d = 1'b0;
        end
      endcase

      if ((state_d == AUX) || !aux_req)
        starve_d = 4'd0;
      else if (starve_q != 4'd15)
        starve_d = starve_q + 4'd1;
    end

    // Registered one clock early so the pulse sits on counter==DOUT_LAT.
    // The counter saturates at 15, so a missing ce_ref cannot re-fire it.
    bootAck_d = (state_q == BOOT) && !ce_ref && (slotCnt_q == LAT_M1);
    auxAck_d  = (state_q == AUX)  && !ce_ref && (slotCnt_q == LAT_M1);

    if (sdOe_q && (slotCnt_q == LAT)) begin
      if (state_q == CPU)
        cpuDout_d = sd_dout;
      if (state_q == AUX)
        auxDout_d = sd_dout;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      slotCnt_q <= 4'd15;
      starve_q  <= 4'd0;
      sdOe_q    <= 1'b0;
      sdWe_q    <= 1'b0;
      sdAddr_q  <= '0;
      sdBank_q  <= '0;
      sdDin_q   <= '0;
      clkRef_q  <= 1'b0;
      bootAck_q <= 1'b0;
      auxAck_q  <= 1'b0;
      cpuDout_q <= 8'hFF;
      auxDout_q <= 8'h00;
    end else begin
      slotCnt_q <= slotCnt_d;
      starve_q  <= starve_d;
      sdOe_q    <= sdOe_d;
      sdWe_q    <= sdWe_d;
      sdAddr_q  <= sdAddr_d;
      sdBank_q  <= sdBank_d;
      sdDin_q   <= sdDin_d;
      clkRef_q  <= ce_ref;
      bootAck_q <= bootAck_d;
      auxAck_q  <= auxAck_d;
      cpuDout_q <= cpuDout_d;
      auxDout_q <= auxDout_d;
    end
  end

  assign sd_oe     = sdOe_q;
  assign sd_we     = sdWe_q;
  assign sd_addr   = sdAddr_q;
  assign sd_bank   = sdBank_q;
  assign sd_din    = sdDin_q;
  assign sd_clkref = clkRef_q;
  assign boot_ack  = bootAck_q;
  assign aux_ack   = auxAck_q;
  assign aux_dout  = auxDout_q;
  // The CPU sees an open bus while the ROM download owns the memory.
  assign cpu_dout  = boot_mode ? 8'hFF : cpuDout_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter. Inputs change and outputs are sampled 1ns
// after each rising edge. Inside a slot, loop index k equals the arbiter's
// slot counter (k=0 is the clock right after the ce_ref edge).
module tb_ram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_ref = 1'b0;
  logic        boot_mode = 1'b0;
  logic        boot_req = 1'b0;
  logic [22:0] boot_addr = '0;
  logic [1:0]  boot_bank = '0;
  logic [7:0]  boot_din = '0;
  logic        boot_ack;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [22:0] cpu_addr = '0;
  logic [1:0]  cpu_bank = '0;
  logic [7:0]  cpu_din = '0;
  logic [7:0]  cpu_dout;
  logic        aux_req = 1'b0;
  logic        aux_we = 1'b0;
  logic [22:0] aux_addr = '0;
  logic [7:0]  aux_din = '0;
  logic        aux_ack;
  logic [7:0]  aux_dout;
  logic        sd_oe;
  logic        sd_we;
  logic [22:0] sd_addr;
  logic [1:0]  sd_bank;
  logic [7:0]  sd_din;
  logic [7:0]  sd_dout = '0;
  logic        sd_clkref;

  int nChecks = 0;
  int nFails  = 0;

  ram_arbiter #(.DOUT_LAT(8), .STARVE_MAX(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref), .boot_mode(boot_mode),
    .boot_req(boot_req), .boot_addr(boot_addr), .boot_bank(boot_bank),
    .boot_din(boot_din), .boot_ack(boot_ack),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_bank(cpu_bank), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_din(aux_din), .aux_ack(aux_ack), .aux_dout(aux_dout),
    .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr), .sd_bank(sd_bank),
    .sd_din(sd_din), .sd_dout(sd_dout), .sd_clkref(sd_clkref)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // Pulse ce_ref for one clock; returns in the k=0 clock of the new slot.
  task automatic startSlot();
    ce_ref = 1'b1;
    tick();
    ce_ref = 1'b0;
  endtask

  // Advance from k=0 to k=15 of the current slot.
  task automatic finishSlot();
    for (int k = 1; k < 16; k++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    nChecks++;
    if (sd_oe !== 1'b0 || sd_we !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_cmd: oe=%b we=%b, required 0 0", sd_oe, sd_we);
    end
    nChecks++;
    if (sd_addr !== 23'd0 || sd_bank !== 2'd0 || sd_din !== 8'd0) begin
      nFails++;
      $display("[TB] FAIL reset_bus: addr=%h bank=%h din=%h, required 0 0 0", sd_addr, sd_bank, sd_din);
    end
    nChecks++;
    if (sd_clkref !== 1'b0 || boot_ack !== 1'b0 || aux_ack !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_strobes: clkref=%b boot_ack=%b aux_ack=%b, required 0 0 0", sd_clkref, boot_ack, aux_ack);
    end
    nChecks++;
    if (cpu_dout !== 8'hFF || aux_dout !== 8'h00) begin
      nFails++;
      $display("[TB] FAIL reset_dout: cpu_dout=%h aux_dout=%h, required ff 00", cpu_dout, aux_dout);
    end
    reset = 1'b0;
    tick();
  endtask

  // Boot write wins even with a CPU read pending; ack lands on k=8.
  task automatic test_boot();
    int ackCnt = 0;
    int ackAt = -1;
    int oeSeen = 0;
    boot_mode = 1'b1;
    boot_req  = 1'b1;
    boot_addr = 23'h400123;
    boot_bank = 2'd2;
    boot_din  = 8'h5A;
    cpu_rd    = 1'b1;
    cpu_addr  = 23'h000777;
    startSlot();
    nChecks++;
    if (sd_we !== 1'b1 || sd_addr !== 23'h400123 || sd_din !== 8'h5A || sd_bank !== 2'd2) begin
      nFails++;
      $display("[TB] FAIL boot_cmd: we=%b addr=%h din=%h bank=%h, required 1 400123 5a 2", sd_we, sd_addr, sd_din, sd_bank);
    end
    nChecks++;
    if (sd_clkref !== 1'b1 || cpu_dout !== 8'hFF) begin
      nFails++;
      $display("[TB] FAIL boot_clkref_dout: clkref=%b cpu_dout=%h, required 1 ff", sd_clkref, cpu_dout);
    end
    cpu_rd = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (sd_oe === 1'b1) oeSeen++;
      if (boot_ack === 1'b1) begin
        ackCnt++;
        ackAt = k;
        boot_req = 1'b0;
      end
      if (k == 1) begin
        nChecks++;
        if (sd_clkref !== 1'b0) begin
          nFails++;
          $display("[TB] FAIL clkref_width: clkref=%b at k=1, required 0", sd_clkref);
        end
      end
      if (k < 15) tick();
    end
    nChecks++;
    if (ackCnt != 1 || ackAt != 8) begin
      nFails++;
      $display("[TB] FAIL boot_ack: count=%0d at k=%0d, required 1 at k=8", ackCnt, ackAt);
    end
    nChecks++;
    if (oeSeen != 0) begin
      nFails++;
      $display("[TB] FAIL boot_no_oe: oe high %0d clocks, required 0", oeSeen);
    end
    boot_mode = 1'b0;
    startSlot();
    nChecks++;
    if (sd_we !== 1'b0 || sd_oe !== 1'b0 || sd_addr !== 23'h400123 || sd_din !== 8'h5A) begin
      nFails++;
      $display("[TB] FAIL idle_hold: we=%b oe=%b addr=%h din=%h, required 0 0 400123 5a", sd_we, sd_oe, sd_addr, sd_din);
    end
    finishSlot();
  endtask

  // boot_mode falls mid-slot: the boot write still completes and is acked.
  task automatic test_boot_fall();
    int ackAt = -1;
    int ackCnt = 0;
    boot_mode = 1'b1;
    boot_req  = 1'b1;
    boot_addr = 23'h000042;
    boot_din  = 8'h11;
    startSlot();
    for (int k = 0; k < 16; k++) begin
      if (k == 3) boot_mode = 1'b0;
      if (boot_ack === 1'b1) begin
        ackCnt++;
        ackAt = k;
        boot_req = 1'b0;
      end
      if (k < 15) tick();
    end
    nChecks++;
    if (ackCnt != 1 || ackAt != 8) begin
      nFails++;
      $display("[TB] FAIL boot_fall_ack: count=%0d at k=%0d, required 1 at k=8", ackCnt, ackAt);
    end
    startSlot();
    nChecks++;
    if (sd_we !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL boot_fall_idle: we=%b, required 0", sd_we);
    end
    finishSlot();
  endtask

  task automatic test_cpu_read();
    int oeLow = 0;
    cpu_rd   = 1'b1;
    cpu_addr = 23'h001000;
    cpu_bank = 2'd1;
    startSlot();
    cpu_rd = 1'b0;
    nChecks++;
    if (sd_addr !== 23'h001000 || sd_bank !== 2'd1 || sd_we !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL cpu_rd_cmd: addr=%h bank=%h we=%b, required 001000 1 0", sd_addr, sd_bank, sd_we);
    end
    for (int k = 0; k < 16; k++) begin
      if (sd_oe !== 1'b1) oeLow++;
      if (k == 8) begin
        nChecks++;
        if (cpu_dout !== 8'hFF) begin
          nFails++;
          $display("[TB] FAIL cpu_early: cpu_dout=%h at k=8, required ff", cpu_dout);
        end
        sd_dout = 8'h3C;
      end
      if (k == 9) begin
        nChecks++;
        if (cpu_dout !== 8'h3C) begin
          nFails++;
          $display("[TB] FAIL cpu_capture: cpu_dout=%h at k=9, required 3c", cpu_dout);
        end
        sd_dout = 8'hC3;
      end
      if (k < 15) tick();
    end
    nChecks++;
    if (oeLow != 0) begin
      nFails++;
      $display("[TB] FAIL cpu_oe_hold: oe low %0d clocks, required 0", oeLow);
    end
    startSlot();
    finishSlot();
    nChecks++;
    if (sd_oe !== 1'b0 || cpu_dout !== 8'h3C) begin
      nFails++;
      $display("[TB] FAIL cpu_hold_idle: oe=%b cpu_dout=%h, required 0 3c", sd_oe, cpu_dout);
    end
  endtask

  // CPU reads every slot while aux waits: aux wins the fifth slot.
  task automatic test_starvation();
    int grantSlot = -1;
    int ackCnt = 0;
    cpu_rd   = 1'b1;
    cpu_addr = 23'h001111;
    aux_req  = 1'b1;
    aux_we   = 1'b0;
    aux_addr = 23'h002222;
    sd_dout  = 8'hA7;
    for (int s = 1; s <= 5; s++) begin
      startSlot();
      if (sd_addr === 23'h002222 && grantSlot < 0) grantSlot = s;
      for (int k = 0; k < 16; k++) begin
        if (aux_ack === 1'b1) begin
          ackCnt++;
          aux_req = 1'b0;
        end
        if (k < 15) tick();
      end
    end
    nChecks++;
    if (grantSlot != 5) begin
      nFails++;
      $display("[TB] FAIL starve_grant: aux granted in slot %0d, required 5", grantSlot);
    end
    nChecks++;
    if (ackCnt != 1) begin
      nFails++;
      $display("[TB] FAIL starve_ack: aux_ack count=%0d, required 1", ackCnt);
    end
    nChecks++;
    if (aux_dout !== 8'hA7) begin
      nFails++;
      $display("[TB] FAIL aux_capture: aux_dout=%h, required a7", aux_dout);
    end
    aux_req = 1'b1;
    startSlot();
    nChecks++;
    if (sd_addr !== 23'h001111 || sd_oe !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL starve_cleared: addr=%h oe=%b, required 001111 1", sd_addr, sd_oe);
    end
    cpu_rd  = 1'b0;
    aux_req = 1'b0;
    finishSlot();
    startSlot();
    finishSlot();
  endtask

  task automatic test_rd_wr_both();
    cpu_rd   = 1'b1;
    cpu_wr   = 1'b1;
    cpu_addr = 23'h000ABC;
    cpu_din  = 8'h77;
    startSlot();
    cpu_rd = 1'b0;
    cpu_wr = 1'b0;
    nChecks++;
    if (sd_we !== 1'b1 || sd_oe !== 1'b0 || sd_din !== 8'h77) begin
      nFails++;
      $display("[TB] FAIL rd_wr_both: we=%b oe=%b din=%h, required 1 0 77", sd_we, sd_oe, sd_din);
    end
    finishSlot();
  endtask

  task automatic test_reset_mid_slot();
    int ackCnt = 0;
    aux_req  = 1'b1;
    aux_we   = 1'b0;
    aux_addr = 23'h003333;
    startSlot();
    nChecks++;
    if (sd_oe !== 1'b1 || sd_addr !== 23'h003333) begin
      nFails++;
      $display("[TB] FAIL aux_rd_cmd: oe=%b addr=%h, required 1 003333", sd_oe, sd_addr);
    end
    for (int k = 1; k <= 5; k++) tick();
    reset   = 1'b1;
    aux_req = 1'b0;
    tick();
    nChecks++;
    if (sd_oe !== 1'b0 || sd_addr !== 23'd0 || sd_clkref !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL midreset_cmd: oe=%b addr=%h clkref=%b, required 0 0 0", sd_oe, sd_addr, sd_clkref);
    end
    nChecks++;
    if (cpu_dout !== 8'hFF || aux_dout !== 8'h00) begin
      nFails++;
      $display("[TB] FAIL midreset_dout: cpu_dout=%h aux_dout=%h, required ff 00", cpu_dout, aux_dout);
    end
    reset = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (aux_ack === 1'b1) ackCnt++;
    end
    nChecks++;
    if (ackCnt != 0) begin
      nFails++;
      $display("[TB] FAIL midreset_ack: aux_ack count=%0d, required 0", ackCnt);
    end
  endtask

  task automatic test_missing_ce();
    int weLow = 0;
    int acks = 0;
    cpu_wr   = 1'b1;
    cpu_addr = 23'h005555;
    cpu_bank = 2'd3;
    cpu_din  = 8'h99;
    startSlot();
    cpu_wr = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (sd_we !== 1'b1) weLow++;
      if (boot_ack === 1'b1 || aux_ack === 1'b1) acks++;
      tick();
    end
    nChecks++;
    if (weLow != 0 || sd_addr !== 23'h005555) begin
      nFails++;
      $display("[TB] FAIL missing_ce_hold: we low %0d clocks, addr=%h, required 0 005555", weLow, sd_addr);
    end
    nChecks++;
    if (acks != 0) begin
      nFails++;
      $display("[TB] FAIL missing_ce_ack: acks=%0d, required 0", acks);
    end
    cpu_rd   = 1'b1;
    cpu_addr = 23'h006666;
    startSlot();
    cpu_rd = 1'b0;
    nChecks++;
    if (sd_oe !== 1'b1 || sd_we !== 1'b0 || sd_addr !== 23'h006666) begin
      nFails++;
      $display("[TB] FAIL missing_ce_resume: oe=%b we=%b addr=%h, required 1 0 006666", sd_oe, sd_we, sd_addr);
    end
    finishSlot();
  endtask

  initial begin
    test_reset();
    test_boot();
    test_boot_fall();
    test_cpu_read();
    test_starvation();
    test_rd_wr_both();
    test_reset_mid_slot();
    test_missing_ce();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
